// File: rtl/message_assembler_pkg.sv
// Shared types and defaults for the message assembler.
// Holds the frame state enum, the default sync marker and default payload length.
package message_assembler_pkg;

   localparam logic [7:0] DEFAULT_SYNC    = 8'h7E;
   localparam int         DEFAULT_MAX_LEN = 16;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_LEN,
      ST_PAYLOAD,
      ST_CHECK,
      ST_DRAIN
   } asm_state_t;

   // Address width for a store of the given depth; never narrower than one bit.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/message_assembler_buffer.sv
// Payload store for the message assembler.
// One synchronous write port, one asynchronous read port, storage is never reset.
module asm_buffer
   import message_assembler_pkg::*;
#(
   parameter int DEPTH = DEFAULT_MAX_LEN,
   parameter int AW    = addr_width(DEPTH)
) (
   input  logic          clock,
   input  logic          wrEn,
   input  logic [AW-1:0] wrAddr,
   input  logic [7:0]    wrData,
   input  logic [AW-1:0] rdAddr,
   output logic [7:0]    rdData
);

   logic [7:0] mem [DEPTH];

   // Capture payload bytes as they arrive.
   always_ff @(posedge clock) begin
      if (wrEn) begin
         mem[wrAddr] <= wrData;
      end
   end

   assign rdData = mem[rdAddr];

endmodule

// File: rtl/message_assembler.sv
// Frame assembler: hunts for SYNC_BYTE, takes LEN, LEN payload bytes and an
// XOR checksum, then presents the payload on a valid/ready output port.
// Optional build macro ASSEMBLER_STATS_EN adds saturating chkErrCount and
// overrunCount outputs.
module message_assembler
   import message_assembler_pkg::*;
#(
   parameter int         MAX_LEN   = DEFAULT_MAX_LEN,
   parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] messageByte,
   input  logic       isNew,
   output logic [7:0] outByte,
   output logic       outValid,
   output logic       outLast,
   input  logic       outReady,
   output logic       chkErr,
   output logic       lenErr,
   output logic       overrun,
   output logic       busy
`ifdef ASSEMBLER_STATS_EN
   ,
   output logic [7:0] chkErrCount,
   output logic [7:0] overrunCount
`endif
);

   localparam int         AW        = addr_width(MAX_LEN);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   asm_state_t state, state_nxt;
   logic [7:0] len_q;
   logic [7:0] chk_q;
   logic [7:0] wr_idx;
   logic [7:0] rd_idx;
   logic [7:0] buf_rd;
   logic       buf_we;
   logic       len_bad;
   logic       chk_ok;
   logic       at_last;
   logic       hs;

   assign len_bad = (messageByte == 8'd0) || (messageByte > MAX_LEN_B);
   assign chk_ok  = (messageByte == chk_q);
   assign at_last = (rd_idx == len_q - 8'd1);
   assign hs      = (state == ST_DRAIN) && outReady;
   assign buf_we  = (state == ST_PAYLOAD) && isNew;

   asm_buffer #(
      .DEPTH (MAX_LEN),
      .AW    (AW)
   ) u_buffer (
      .clock  (clock),
      .wrEn   (buf_we),
      .wrAddr (wr_idx[AW-1:0]),
      .wrData (messageByte),
      .rdAddr (rd_idx[AW-1:0]),
      .rdData (buf_rd)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_HUNT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: byte-driven through the frame, handshake-driven while draining.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_HUNT: begin
            if (isNew && (messageByte == SYNC_BYTE)) state_nxt = ST_LEN;
         end
         ST_LEN: begin
            if (isNew) state_nxt = len_bad ? ST_HUNT : ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (isNew && (wr_idx == len_q - 8'd1)) state_nxt = ST_CHECK;
         end
         ST_CHECK: begin
            if (isNew) state_nxt = chk_ok ? ST_DRAIN : ST_HUNT;
         end
         ST_DRAIN: begin
            if (hs && at_last) state_nxt = ST_HUNT;
         end
         default: state_nxt = ST_HUNT;
      endcase
   end

   // Output decode: payload is presented straight from the buffer while draining.
   always_comb begin
      outValid = 1'b0;
      outByte  = 8'd0;
      outLast  = 1'b0;
      busy     = (state != ST_HUNT);
      if (state == ST_DRAIN) begin
         outValid = 1'b1;
         outByte  = buf_rd;
         outLast  = at_last;
      end
   end

   // Length, checksum, indices and one-cycle error pulses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         len_q   <= 8'd0;
         chk_q   <= 8'd0;
         wr_idx  <= 8'd0;
         rd_idx  <= 8'd0;
         chkErr  <= 1'b0;
         lenErr  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         chkErr  <= 1'b0;
         lenErr  <= 1'b0;
         overrun <= 1'b0;
         case (state)
            ST_LEN: begin
               if (isNew) begin
                  if (len_bad) begin
                     lenErr <= 1'b1;
                  end else begin
                     len_q  <= messageByte;
                     chk_q  <= messageByte;
                     wr_idx <= 8'd0;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (isNew) begin
                  chk_q  <= chk_q ^ messageByte;
                  wr_idx <= wr_idx + 8'd1;
               end
            end
            ST_CHECK: begin
               if (isNew) begin
                  if (chk_ok) rd_idx <= 8'd0;
                  else        chkErr <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (hs)    rd_idx  <= rd_idx + 8'd1;
               if (isNew) overrun <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ASSEMBLER_STATS_EN
   // Counter increment that sticks at full scale.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Saturating event counters fed by the error pulses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         chkErrCount  <= 8'd0;
         overrunCount <= 8'd0;
      end else begin
         if (chkErr)  chkErrCount  <= sat_inc(chkErrCount);
         if (overrun) overrunCount <= sat_inc(overrunCount);
      end
   end
`endif

endmodule

// File: tb/tb_message_assembler.sv
// Scoreboard bench for message_assembler: stimulus pushes expected payload
// bytes and pulse counts, a negedge monitor pops and compares.
module tb_message_assembler;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] messageByte = 8'd0;
   logic       isNew = 1'b0;
   logic       outReady = 1'b0;
   logic [7:0] outByte;
   logic       outValid, outLast, chkErr, lenErr, overrun, busy;
`ifdef ASSEMBLER_STATS_EN
   logic [7:0] chkErrCount, overrunCount;
`endif

   message_assembler dut (
      .clock       (clock),
      .reset       (reset),
      .messageByte (messageByte),
      .isNew       (isNew),
      .outByte     (outByte),
      .outValid    (outValid),
      .outLast     (outLast),
      .outReady    (outReady),
      .chkErr      (chkErr),
      .lenErr      (lenErr),
      .overrun     (overrun),
      .busy        (busy)
`ifdef ASSEMBLER_STATS_EN
      ,
      .chkErrCount  (chkErrCount),
      .overrunCount (overrunCount)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] b;
      logic       l;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;
   int n_chk = 0, n_len = 0, n_ovr = 0;
   int e_chk = 0, e_len = 0, e_ovr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic send(input logic [7:0] b);
      messageByte = b;
      isNew = 1'b1;
      @(posedge clock);
      #1;
      isNew = 1'b0;
      messageByte = 8'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] b, input logic l);
      exp_t e;
      e.b = b;
      e.l = l;
      q.push_back(e);
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_chkErr_pulses"}, n_chk, e_chk);
      check({tag, "_lenErr_pulses"}, n_len, e_len);
      check({tag, "_overrun_pulses"}, n_ovr, e_ovr);
   endtask

   // Monitor: counts pulses, pops the scoreboard on every handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            if (chkErr)  n_chk++;
            if (lenErr)  n_len++;
            if (overrun) n_ovr++;
            if (outValid && outReady) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_out: actual=%0h required=none", outByte);
               end else begin
                  e = q.pop_front();
                  check("out_byte", outByte, e.b);
                  check("out_last", outLast, e.l);
               end
            end else if (!outValid) begin
               check("idle_outputs_zero", {outByte, outLast}, 32'd0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", busy, 0);
      check("rst_outValid", outValid, 0);
      check("rst_outByte", outByte, 0);
      check("rst_outLast", outLast, 0);
      check("rst_chkErr", chkErr, 0);
      check("rst_lenErr", lenErr, 0);
      check("rst_overrun", overrun, 0);
      reset = 1'b1;
      idle(2);

      // Good 3-byte frame, consumer always ready
      outReady = 1'b1;
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      push(8'h33, 1'b1);
      send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
      check("first_byte_latency", {outValid, outByte}, {1'b1, 8'h11});
      idle(3);
      check("t1_busy_after", busy, 0);
      check_counts("t1");

      // Bad checksum (02^AA^BB = 13, sent 00), then a good frame
      send(8'h7E); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
      e_chk++;
      check("t2_busy_after_err", busy, 0);
      idle(2);
      check_counts("t2a");
      push(8'h5A, 1'b1);
      send(8'h7E); send(8'h01); send(8'h5A); send(8'h5B);
      idle(2);
      check("t2_busy_after_good", busy, 0);

      // Illegal lengths 0 and 17
      send(8'h7E); send(8'h00);
      e_len++;
      check("t3_busy_len0", busy, 0);
      send(8'h7E); send(8'h11);
      e_len++;
      check("t3_busy_len17", busy, 0);
      idle(2);
      check_counts("t3");

      // Stalled drain with overruns; payload C3 7E (sync as data), chk 02^C3^7E = BF
      outReady = 1'b0;
      send(8'h7E); send(8'h02); send(8'hC3); send(8'h7E); send(8'hBF);
      for (int i = 0; i < 5; i++) begin
         check("t4_stall_hold", {outValid, outByte, outLast}, {1'b1, 8'hC3, 1'b0});
         if (i == 1 || i == 3) send(8'h55);
         else idle(1);
      end
      e_ovr += 2;
      push(8'hC3, 1'b0);
      push(8'h7E, 1'b1);
      outReady = 1'b1;
      idle(1);
      check("t4_second_byte", {outValid, outByte, outLast}, {1'b1, 8'h7E, 1'b1});
      send(8'h66);
      e_ovr++;
      check("t4_busy_after_last", busy, 0);
      idle(2);
      check_counts("t4");

      // Reset during payload, then a clean frame
      send(8'h7E); send(8'h04); send(8'h01); send(8'h02);
      check("t5_busy_mid_frame", busy, 1);
      reset = 1'b0;
      #2;
      check("t5_busy_in_reset", busy, 0);
      check("t5_outValid_in_reset", outValid, 0);
      #1;
      reset = 1'b1;
      idle(1);
      push(8'h10, 1'b0);
      push(8'h20, 1'b1);
      send(8'h7E); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
      idle(3);
      check("t5_busy_after", busy, 0);
      check_counts("t5");

`ifdef ASSEMBLER_STATS_EN
      check("stats_chk_after_reset", chkErrCount, 0);
      for (int i = 0; i < 300; i++) begin
         send(8'h7E); send(8'h01); send(8'h00); send(8'h00);
      end
      e_chk += 300;
      idle(2);
      check("stats_chk_saturated", chkErrCount, 8'd255);
      check("stats_overrun_count", overrunCount, 0);
`endif

      check("queue_empty", q.size(), 0);
      check_counts("final");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
